// File: rtl/mdu_ctrl_if.sv
// Bus between the E-stage pipeline and the multiply/divide controller.
// Signal names match the pipeline's MDU_* nets so the interface drops in directly.
interface mdu_ctrl_if;
    logic [31:0] MDU_src1;
    logic [31:0] MDU_src2;
    logic [3:0]  MDU_op;
    logic        MDU_start;
    logic        MDU_busy;
    logic        MDU_stall_req;
    logic [31:0] E_MDU_result;
    logic [31:0] MDU_hi;
    logic [31:0] MDU_lo;

    // Pipeline side: issues operations, observes status and results
    modport master (
        output MDU_src1, MDU_src2, MDU_op, MDU_start,
        input  MDU_busy, MDU_stall_req, E_MDU_result, MDU_hi, MDU_lo
    );

    // Controller side
    modport slave (
        input  MDU_src1, MDU_src2, MDU_op, MDU_start,
        output MDU_busy, MDU_stall_req, E_MDU_result, MDU_hi, MDU_lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, sequences a fixed-latency
// mult/div, serves mfhi/mflo/mthi/mtlo, and raises the stall request.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    mdu_ctrl_if.slave    bus
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_op;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic            r_busy;

    logic            w_launch;
    logic [63:0]     w_prod;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [31:0]     w_a_mag;
    logic [31:0]     w_b_mag;
    logic [31:0]     w_div_b;
    logic [31:0]     w_q_mag;
    logic [31:0]     w_r_mag;
    logic [31:0]     w_new_hi;
    logic [31:0]     w_new_lo;
    logic [31:0]     w_result;

    assign w_launch = bus.MDU_start &&
                      (bus.MDU_op >= OP_MULT) && (bus.MDU_op <= OP_DIVU);

    // Result datapath from the latched operands. Signed division works on
    // magnitudes so 0x80000000 / -1 wraps to 0x80000000 with zero remainder.
    always_comb begin
        w_prod   = 64'd0;
        w_a_neg  = (r_op == OP_DIV) && r_a[31];
        w_b_neg  = (r_op == OP_DIV) && r_b[31];
        w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
        w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
        w_div_b  = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
        w_q_mag  = w_a_mag / w_div_b;
        w_r_mag  = w_a_mag % w_div_b;
        w_new_hi = r_hi;
        w_new_lo = r_lo;
        case (r_op)
            OP_MULT: begin
                w_prod   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
                w_new_hi = w_prod[63:32];
                w_new_lo = w_prod[31:0];
            end
            OP_MULTU: begin
                w_prod   = {32'd0, r_a} * {32'd0, r_b};
                w_new_hi = w_prod[63:32];
                w_new_lo = w_prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (r_b != 32'd0) begin
                    w_new_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
                    w_new_hi = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
                end else begin
                    w_new_lo = r_lo;
                    w_new_hi = r_hi;
                end
            end
            default: begin
                w_new_hi = r_hi;
                w_new_lo = r_lo;
            end
        endcase
    end

    // mfhi/mflo read port: current register value, zero for any other op
    always_comb begin
        w_result = 32'd0;
        case (bus.MDU_op)
            OP_MFHI: w_result = r_hi;
            OP_MFLO: w_result = r_lo;
            default: w_result = 32'd0;
        endcase
    end

    // Controller FSM: launch, count down, commit HI/LO; mthi/mtlo only when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_op    <= bus.MDU_op;
                        r_a     <= bus.MDU_src1;
                        r_b     <= bus.MDU_src2;
                        r_cnt   <= (bus.MDU_op <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                    end else if (bus.MDU_op == OP_MTHI) begin
                        r_hi <= bus.MDU_src1;
                    end else if (bus.MDU_op == OP_MTLO) begin
                        r_lo <= bus.MDU_src1;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CW'(1)) begin
                        r_hi    <= w_new_hi;
                        r_lo    <= w_new_lo;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.MDU_busy      = r_busy;
    assign bus.MDU_stall_req = bus.MDU_start | r_busy;
    assign bus.E_MDU_result  = w_result;
    assign bus.MDU_hi        = r_hi;
    assign bus.MDU_lo        = r_lo;
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- E-stage multiply/divide controller for the P6 pipeline; sits beside the ALU and sequences the multi-cycle mult/div datapath.
- Owns the HI/LO registers and a busy counter.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Drives the stall request the hazard unit uses to hold MDU-class instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- MDU_src1  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
- MDU_src2  input  32  rt operand (divisor / multiplier)
- MDU_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
- MDU_start  input  1  one-cycle launch qualifier for ops 1-4
- MDU_busy  output  1  registered; high while a mult/div is in flight
- MDU_stall_req  output  1  combinational: MDU_start | MDU_busy
- E_MDU_result  output  32  combinational read: HI for op 7, LO for op 8, else 0
- MDU_hi  output  32  current HI register
- MDU_lo  output  32  current LO register

Behaviour:
- Reset state: HI=0, LO=0, busy=0, counter=0, state IDLE. All outputs are 0 after reset with MDU_start=0.
- Reset wins over every other event in the same cycle. Reset mid-operation aborts the op and discards its result; HI/LO become 0.
- FSM has two states, IDLE and BUSY.
- IDLE -> BUSY: edge where MDU_start=1 and MDU_op is in 1-4.
  - src1/src2 and op are latched.
  - Counter is loaded with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4).
- BUSY: counter decrements each edge. On the edge where counter==1, HI/LO are written and the FSM returns to IDLE.
- Latency: with start at cycle t, MDU_busy is high during cycles t+1 .. t+N. New HI/LO are visible from cycle t+N+1, when busy=0.
- MDU_start with op outside 1-4: no state change.
- MDU_start while BUSY is ignored: latched operands are not disturbed and the counter is not reloaded. The hazard unit never does this.
- Arithmetic:
  - mult: signed 32x32 to 64; multu: unsigned. HI=prod[63:32], LO=prod[31:0].
  - div/divu: LO=quotient, HI=remainder. Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Special case: 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - Divide by zero: op still takes DIV_CYCLES; HI and LO are left unchanged.
- mthi/mtlo (ops 5/6, MDU_start not required): write src1 into HI/LO at the next edge, only when IDLE. When BUSY they are ignored.
- mfhi/mflo: E_MDU_result reflects the current register value in the same cycle. When BUSY it shows the old value; the stall request guarantees it is never consumed then.
- The result is computed from the latched operands. Operand inputs may change freely after the start cycle.

Test Plan:
- Reset then idle: all outputs 0; mfhi and mflo both return 0.
- mult 0xFFFFFFFE x 3, start at t: busy high t+1..t+5, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div -7 / 2: busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 gives LO=3, HI=1.
- Divide by zero after mthi 0x11, mtlo 0x22: busy high 10 cycles, HI=0x11 and LO=0x22 afterwards.
- Conflicts:
  - mtlo 0x55 issued while BUSY: LO ends up as the mult result, not 0x55.
  - Second MDU_start during BUSY: counter and result unaffected.
  - MDU_stall_req is high in the start cycle and in every busy cycle.
- Reset asserted at the 3rd busy cycle of a div: next cycle busy=0 and HI=LO=0; no late write occurs.
